// File: rtl/ps2_pkg.sv
// Shared PS/2 framing constants and the parity helper used by the
// receiver, the keyboard model and the host-to-device transmitter.
package ps2_pkg;

  // start + 8 data + parity + stop
  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  // Parity bit that makes the 8 data bits plus parity contain an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] code);
    return ~^code;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead synchronous FIFO for received scan codes. Pointers carry one
// extra wrap bit so full and empty are told apart without a count register.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Head is read straight from the array so a fresh entry is visible with valid;
  // the empty mask keeps data at zero after reset.
  assign head = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

  // Pointer update; wrap-around is plain modulo arithmetic on the extended width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronizes the pins, detects falling
// ps2_clk edges, deframes 11-bit frames, discards stalled partial frames
// and queues good scan codes behind a valid/ready port.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_prev_reg;
  logic [9:0]             shift_reg;
  logic [3:0]             bit_cnt_reg;
  logic [TW-1:0]          timeout_reg;
  logic                   frame_err_reg;
  logic                   overflow_reg;

  logic ps2_clk_s;
  logic ps2_data_s;
  logic fall;
  logic frame_done;
  logic frame_good;
  logic timeout_hit;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;

  assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];
  assign fall       = clk_prev_reg & ~ps2_clk_s;

  // The stop bit is the live sample; the register holds start..parity.
  assign frame_done = fall && (bit_cnt_reg == LAST_BIT);
  assign frame_good = (shift_reg[0] == PS2_START) &&
                      (shift_reg[9] == ps2_odd_parity(shift_reg[8:1])) &&
                      (ps2_data_s == PS2_STOP);
  assign timeout_hit = (timeout_reg == TW'(TIMEOUT_CYCLES));

  assign fifo_pop  = valid & ready;
  assign fifo_push = frame_done & frame_good;

  // Pin synchronizers and edge history idle high, matching a released bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      clk_prev_reg  <= ps2_clk_s;
    end
  end

  // Deframer: shift bits in LSB-first, count them, restart on frame end or stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (fall) begin
      shift_reg   <= {ps2_data_s, shift_reg[9:1]};
      bit_cnt_reg <= frame_done ? 4'd0 : bit_cnt_reg + 4'd1;
    end else if (timeout_hit) begin
      bit_cnt_reg <= '0;
    end
  end

  // Stall timer only runs inside a frame and restarts on every clock fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= '0;
    end else if (bit_cnt_reg == 4'd0 || fall || timeout_hit) begin
      timeout_reg <= '0;
    end else begin
      timeout_reg <= timeout_reg + 1'b1;
    end
  end

  // Status: one-cycle error pulse, sticky overflow where a new drop beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      frame_err_reg <= frame_done & ~frame_good;
      if (fifo_push & fifo_full & ~fifo_pop) overflow_reg <= 1'b1;
      else if (overflow_clr)                 overflow_reg <= 1'b0;
    end
  end

  ps2_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (shift_reg[8:1]),
    .pop       (fifo_pop),
    .head      (data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign valid     = ~fifo_empty;
  assign frame_err = frame_err_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed and randomized checks of the PS/2 receiver against a
// queue-based model of the frame rules.
module tb_ps2_keyboard_rx;

  localparam int FIFO_DEPTH     = 8;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err0;
  int half = 20;
  int vlat;
  int elat;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  // Pop monitor and error-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid && ready) got.push_back(data);
    if (!rst && frame_err) err_seen++;
  end

  // Bound on total run length.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drive the first nbits of a frame; odd parity computed from the data bit count.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit flip_par, input bit stop_val);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (($countones(b) % 2) == 0) ^ flip_par;
    f[10]   = stop_val;
    vlat = -1;
    elat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(half);
      ps2_clk = 1'b0;
      for (int c = 1; c <= half; c++) begin
        @(posedge clk);
        #1;
        if (i == 10 && valid && vlat < 0) vlat = c;
        if (i == 10 && frame_err && elat < 0) elat = c;
        #1;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(half);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 11, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    int k;
    bit ovf_exp;

    // Reset state
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    ready = 1'b1;
    tick(5);

    // Single good frame: latency and one pop
    got.delete();
    err0 = err_seen;
    send(8'h1C);
    check("t1_latency", vlat, SYNC_STAGES + 1);
    check("t1_pops", got.size(), 1);
    check("t1_data", got[0], 8'h1C);
    check("t1_no_err", err_seen - err0, 0);
    $display("frame 0x1c latency=%0d pops=%0d", vlat, got.size());

    // Inverted parity
    got.delete();
    err0 = err_seen;
    send_bits(8'h1C, 11, 1'b1, 1'b1);
    check("t2_err_latency", elat, SYNC_STAGES + 1);
    check("t2_err_count", err_seen - err0, 1);
    check("t2_no_pop", got.size(), 0);
    $display("frame 0x1c bad parity err_latency=%0d", elat);

    // Stop bit low
    got.delete();
    err0 = err_seen;
    send_bits(8'h1C, 11, 1'b0, 1'b0);
    check("t3_err_latency", elat, SYNC_STAGES + 1);
    check("t3_err_count", err_seen - err0, 1);
    check("t3_no_pop", got.size(), 0);
    $display("frame 0x1c bad stop err_latency=%0d", elat);

    // Fill FIFO, then overflow
    ready = 1'b0;
    got.delete();
    for (int i = 1; i <= FIFO_DEPTH; i++) send(8'(i));
    check("t4_no_ovf_when_full", overflow, 0);
    check("t4_head", data, 8'h01);
    send(8'h09);
    check("t4_ovf_set", overflow, 1);
    ready = 1'b1;
    tick(FIFO_DEPTH + 4);
    check("t4_pop_count", got.size(), FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH; i++) check("t4_pop_order", got[i], 8'(i + 1));
    check("t4_drained", valid, 0);
    check("t4_ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("t4_ovf_clr", overflow, 0);
    $display("overflow run pops=%0d", got.size());

    // Break sequence back-to-back
    got.delete();
    err0 = err_seen;
    send(8'hF0);
    send(8'h1C);
    check("t5_pops", got.size(), 2);
    check("t5_first", got[0], 8'hF0);
    check("t5_second", got[1], 8'h1C);
    check("t5_no_err", err_seen - err0, 0);
    $display("break sequence pops=%0d", got.size());

    // Reset mid-frame with a queued byte
    ready = 1'b0;
    send(8'($urandom));
    send_bits(8'h5A, 5, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", valid, 0);
    check("t6_rst_data", data, 0);
    check("t6_rst_frame_err", frame_err, 0);
    check("t6_rst_overflow", overflow, 0);
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    got.delete();
    tick(2);
    send(8'h5A);
    check("t6_pops", got.size(), 1);
    check("t6_data", got[0], 8'h5A);
    $display("post-reset frame pops=%0d", got.size());

    // Partial frame abandoned by timeout
    got.delete();
    err0 = err_seen;
    send_bits(8'h29, 4, 1'b0, 1'b1);
    tick(TIMEOUT_CYCLES + 10);
    send(8'h29);
    check("t7_pops", got.size(), 1);
    check("t7_data", got[0], 8'h29);
    check("t7_no_err", err_seen - err0, 0);
    $display("timeout recovery pops=%0d", got.size());

    // Random stream, consumer always ready
    got.delete();
    exp_q.delete();
    err0 = err_seen;
    k = 0;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 7);
      half = $urandom_range(10, 25);
      send_bits(b, 11, kind == 0, kind != 1);
      if (kind > 1) exp_q.push_back(b);
      else k++;
    end
    check("t8_pops", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("t8_data", got[i], exp_q[i]);
    check("t8_errs", err_seen - err0, k);
    $display("random stream good=%0d bad=%0d", exp_q.size(), k);

    // Random burst with consumer stalled
    got.delete();
    exp_q.delete();
    ovf_exp = 1'b0;
    ready = 1'b0;
    k = $urandom_range(6, 12);
    for (int n = 0; n < k; n++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 5);
      half = $urandom_range(10, 25);
      send_bits(b, 11, kind == 0, 1'b1);
      if (kind != 0) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
        else ovf_exp = 1'b1;
      end
    end
    check("t9_overflow", overflow, ovf_exp);
    ready = 1'b1;
    tick(FIFO_DEPTH + 4);
    check("t9_pops", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("t9_data", got[i], exp_q[i]);
    $display("stalled burst frames=%0d queued=%0d overflow=%0d", k, exp_q.size(), ovf_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
